// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant Montgomery squaring sequencer:
// FSM state encoding, one-hot multiplier mode codes and operand-mux selects.
package redun_mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ   = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [2:0] CTL_NONE   = 3'b000;
    localparam logic [2:0] CTL_SQ     = 3'b001;
    localparam logic [2:0] CTL_MUL_LO = 3'b010;
    localparam logic [2:0] CTL_MUL_HI = 3'b100;

    typedef enum logic [1:0] {
        SEL_A_X    = 2'd0,
        SEL_A_T_LO = 2'd1,
        SEL_A_Q    = 2'd2
    } sel_a_t;

    typedef enum logic [1:0] {
        SEL_B_X       = 2'd0,
        SEL_B_M_PRIME = 2'd1,
        SEL_B_N       = 2'd2
    } sel_b_t;

    // Dwell counter width; covers the full MUL_LAT range 1..7.
    localparam int TIMER_W = 3;

    function automatic logic is_op_state(state_t s);
        return (s == ST_SQ) || (s == ST_LO) || (s == ST_HI);
    endfunction

endpackage

// File: rtl/mul_op_timer.sv
// Dwell timer for one multiplier operation. Cleared while i_clear is high,
// so the first dwell cycle of an operation always sees count 0; o_last
// flags the cycle where the multiplier output is valid (count == MUL_LAT).
import redun_mont_pkg::*;

module mul_op_timer #(
    parameter int MUL_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_last
);

    logic [TIMER_W-1:0] cnt;

    assign o_last = (cnt == TIMER_W'(MUL_LAT));

    // Count up through the dwell, park on the last cycle, restart on clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (!o_last) begin
            cnt <= cnt + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/redun_mont_sq_sequencer.sv
// Sequencer for repeated Montgomery squarings: per iteration it issues
// square (X*X -> T), multiply-low (T_lo*M' -> Q) and multiply-high
// (Q*N + T_hi -> X), each held for MUL_LAT+1 cycles with a capture strobe on
// the last one. Optional cycle counter: define REDUN_MONT_SEQ_PERF_CNT_EN.
// Valid/ready style: i_start is a request accepted only in IDLE (with no
// abort in the same cycle); o_done is a single-cycle completion pulse.
import redun_mont_pkg::*;

module redun_mont_sq_sequencer #(
    parameter int ITER_W  = 32,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 48
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ITER_W-1:0] i_iter,
    input  logic              i_abort,
    output logic [2:0]        o_mul_ctl,
    output logic [1:0]        o_sel_a,
    output logic [1:0]        o_sel_b,
    output logic              o_add_en,
    output logic              o_cap_t,
    output logic              o_cap_q,
    output logic              o_cap_x,
    output logic              o_busy,
    output logic              o_done,
    output logic [ITER_W-1:0] o_iter_cnt,
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0]  o_cycle_cnt,
`endif
    output logic [2:0]        o_dbg_state
);

    if (MUL_LAT < 1 || MUL_LAT > 7 || CNT_W < 1 || ITER_W < 1) begin : g_bad_param
        $error("redun_mont_sq_sequencer: parameter out of range");
    end

    state_t            state;
    sel_a_t            sel_a;
    sel_b_t            sel_b;
    logic [ITER_W-1:0] target;
    logic [ITER_W-1:0] iter_next;
    logic              op_last;
    logic              timer_clear;
    logic              start_ok;

    assign start_ok    = (state == ST_IDLE) && i_start && !i_abort;
    assign iter_next   = o_iter_cnt + ITER_W'(1);
    assign timer_clear = !is_op_state(state) || op_last;

    assign o_sel_a     = sel_a;
    assign o_sel_b     = sel_b;
    assign o_dbg_state = state;

    // Strobes come straight from state and timer so one still fires in the
    // cycle an abort is seen, even though the state will not advance.
    assign o_cap_t = (state == ST_SQ) && op_last;
    assign o_cap_q = (state == ST_LO) && op_last;
    assign o_cap_x = (state == ST_HI) && op_last;

    mul_op_timer #(
        .MUL_LAT (MUL_LAT)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (timer_clear),
        .o_last  (op_last)
    );

    // Control FSM; mode/select/busy/done outputs are registered alongside
    // the state so they are stable for the whole dwell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_mul_ctl  <= CTL_NONE;
            sel_a      <= SEL_A_X;
            sel_b      <= SEL_B_X;
            o_add_en   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_iter_cnt <= '0;
            target     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        target     <= i_iter;
                        o_iter_cnt <= '0;
                        if (i_iter == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= ST_SQ;
                            o_mul_ctl <= CTL_SQ;
                            sel_a     <= SEL_A_X;
                            sel_b     <= SEL_B_X;
                            o_add_en  <= 1'b0;
                            o_busy    <= 1'b1;
                        end
                    end
                end
                ST_SQ, ST_LO, ST_HI: begin
                    if (i_abort) begin
                        state     <= ST_IDLE;
                        o_mul_ctl <= CTL_NONE;
                        sel_a     <= SEL_A_X;
                        sel_b     <= SEL_B_X;
                        o_add_en  <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (op_last) begin
                        if (state == ST_SQ) begin
                            state     <= ST_LO;
                            o_mul_ctl <= CTL_MUL_LO;
                            sel_a     <= SEL_A_T_LO;
                            sel_b     <= SEL_B_M_PRIME;
                            o_add_en  <= 1'b0;
                        end else if (state == ST_LO) begin
                            state     <= ST_HI;
                            o_mul_ctl <= CTL_MUL_HI;
                            sel_a     <= SEL_A_Q;
                            sel_b     <= SEL_B_N;
                            o_add_en  <= 1'b1;
                        end else begin
                            o_iter_cnt <= iter_next;
                            if (iter_next == target) begin
                                state     <= ST_DONE;
                                o_mul_ctl <= CTL_NONE;
                                sel_a     <= SEL_A_X;
                                sel_b     <= SEL_B_X;
                                o_add_en  <= 1'b0;
                                o_busy    <= 1'b0;
                                o_done    <= 1'b1;
                            end else begin
                                state     <= ST_SQ;
                                o_mul_ctl <= CTL_SQ;
                                sel_a     <= SEL_A_X;
                                sel_b     <= SEL_B_X;
                                o_add_en  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
    // Busy-cycle counter: cleared on accepted start, saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_cnt <= '0;
        end else if (start_ok) begin
            o_cycle_cnt <= '0;
        end else if (o_busy && (o_cycle_cnt != '1)) begin
            o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_redun_mont_sq_sequencer.sv
// Bench for redun_mont_sq_sequencer: two instances (MUL_LAT=1 and MUL_LAT=3)
// checked cycle by cycle against an arithmetic trace model of a run.
module tb_redun_mont_sq_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_v [2];
    logic [31:0] iter_v  [2];
    logic        abort_v [2];
    logic [2:0]  ctl_v   [2];
    logic [1:0]  sa_v    [2];
    logic [1:0]  sb_v    [2];
    logic        add_v   [2];
    logic        ct_v    [2];
    logic        cq_v    [2];
    logic        cx_v    [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [31:0] cnt_v   [2];
    logic [2:0]  st_v    [2];
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
    logic [47:0] cyc_v   [2];
`endif

    int          vectors;
    int          miscompares;
    logic [31:0] last_cnt [2];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // ---------------- DUTs ----------------
    redun_mont_sq_sequencer #(.ITER_W(32), .MUL_LAT(1), .CNT_W(48)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_iter(iter_v[0]),
        .i_abort(abort_v[0]), .o_mul_ctl(ctl_v[0]), .o_sel_a(sa_v[0]), .o_sel_b(sb_v[0]),
        .o_add_en(add_v[0]), .o_cap_t(ct_v[0]), .o_cap_q(cq_v[0]), .o_cap_x(cx_v[0]),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_iter_cnt(cnt_v[0]),
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
        .o_cycle_cnt(cyc_v[0]),
`endif
        .o_dbg_state(st_v[0])
    );

    redun_mont_sq_sequencer #(.ITER_W(32), .MUL_LAT(3), .CNT_W(48)) dut_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_iter(iter_v[1]),
        .i_abort(abort_v[1]), .o_mul_ctl(ctl_v[1]), .o_sel_a(sa_v[1]), .o_sel_b(sb_v[1]),
        .o_add_en(add_v[1]), .o_cap_t(ct_v[1]), .o_cap_q(cq_v[1]), .o_cap_x(cx_v[1]),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_iter_cnt(cnt_v[1]),
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
        .o_cycle_cnt(cyc_v[1]),
`endif
        .o_dbg_state(st_v[1])
    );

    // A start seen while busy must not restart the run or clear the count.
    for (genvar g = 0; g < 2; g++) begin : g_ign_start
        assert property (@(posedge clk) disable iff (!rst_n)
            (busy_v[g] && start_v[g] && !abort_v[g]) |=>
            ((busy_v[g] || done_v[g]) && (cnt_v[g] >= $past(cnt_v[g]))))
        else $display("FAIL start_ignored dut%0d: got restart want ignored", g);
    end

    // ---------------- reference model ----------------
    function automatic longint done_cycle(int lat, longint n);
        return (n == 0) ? 64'sd1 : 3 * (lat + 1) * n + 1;
    endfunction

    // Expected outputs in cycle k after a start in cycle 0; a < 0 means no abort.
    function automatic logic [44:0] model(int lat, longint n, longint k, longint a);
        longint p   = lat + 1;
        longint per = 3 * p;
        longint dk  = done_cycle(lat, n);
        logic [2:0]  ctl = 3'b000;
        logic [1:0]  sa = 2'd0, sb = 2'd0;
        logic        add = 1'b0, ct = 1'b0, cq = 1'b0, cx = 1'b0, busy = 1'b0, done = 1'b0;
        logic [31:0] cnt;
        int          op, pos;
        if (a >= 0 && k > a) begin
            cnt = 32'((a - 1) / per);
        end else if (k < dk) begin
            op   = int'(((k - 1) / p) % 3);
            pos  = int'((k - 1) % p);
            busy = 1'b1;
            ctl  = 3'(1 << op);
            sa   = 2'(op);
            sb   = 2'(op);
            add  = (op == 2);
            ct   = (op == 0) && (pos == lat);
            cq   = (op == 1) && (pos == lat);
            cx   = (op == 2) && (pos == lat);
            cnt  = 32'((k - 1) / per);
        end else begin
            done = (k == dk);
            cnt  = 32'(n);
        end
        return {ctl, sa, sb, add, ct, cq, cx, busy, done, cnt};
    endfunction

    function automatic logic [44:0] pack_obs(int d);
        return {ctl_v[d], sa_v[d], sb_v[d], add_v[d], ct_v[d], cq_v[d], cx_v[d],
                busy_v[d], done_v[d], cnt_v[d]};
    endfunction

    // ---------------- driver + checker ----------------
    task automatic run_check(input int d, input string name, input longint n,
                             input longint a, input longint kmax, input bit noise);
        int          lat = (d == 1) ? 3 : 1;
        longint      dk  = done_cycle(lat, n);
        logic [44:0] exp_v;
        logic [44:0] got_v;
        @(negedge clk);
        start_v[d] = 1'b1;
        iter_v[d]  = 32'(n);
        abort_v[d] = 1'b0;
        for (longint k = 1; k <= kmax; k++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            exp_v = model(lat, n, k, a);
            got_v = pack_obs(d);
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, d, k, got_v, exp_v);
            end
            vectors++;
            if (!$onehot0(ctl_v[d])) begin
                miscompares++;
                $display("FAIL %s_onehot dut%0d cycle %0d: got ctl %b want one-hot or zero",
                         name, d, k, ctl_v[d]);
            end
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
            if (k == 1) begin
                vectors++;
                if (cyc_v[d] !== 48'd0) begin
                    miscompares++;
                    $display("FAIL %s_cyc_clear dut%0d: got %0d want 0", name, d, cyc_v[d]);
                end
            end
`endif
            if (k == a) begin
                abort_v[d] = 1'b1;
            end else if (noise && k < dk && (a < 0 || k < a)) begin
                start_v[d] = 1'($urandom_range(0, 1));
                iter_v[d]  = $urandom;
            end
        end
        last_cnt[d] = model(lat, n, kmax, a) >> 0;
`ifdef REDUN_MONT_SEQ_PERF_CNT_EN
        vectors++;
        if (cyc_v[d] !== 48'((a >= 0) ? a : dk - 1)) begin
            miscompares++;
            $display("FAIL %s_cyc_total dut%0d: got %0d want %0d", name, d, cyc_v[d],
                     (a >= 0) ? a : dk - 1);
        end
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; abort_v[d] = 1'b0; iter_v[d] = '0; last_cnt[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (pack_obs(d) !== 45'd0 || st_v[d] !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got %h st %0d want 0", d, pack_obs(d), st_v[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (pack_obs(d) !== 45'd0) begin
                miscompares++;
                $display("FAIL reset_idle dut%0d: got %h want 0", d, pack_obs(d));
            end
        end
    endtask

    task automatic test_two_iter();
        run_check(0, "two_iter", 2, -1, done_cycle(1, 2) + 1, 0);
    endtask

    task automatic test_zero_iter();
        run_check(0, "zero_iter_l1", 0, -1, 3, 0);
        run_check(1, "zero_iter_l3", 0, -1, 3, 0);
    endtask

    task automatic test_lat3();
        run_check(1, "lat3", 1, -1, done_cycle(3, 1) + 1, 0);
    endtask

    task automatic test_abort();
        run_check(0, "abort", 5, 9, 10, 0);
        run_check(0, "restart", 2, -1, done_cycle(1, 2) + 1, 1);
    endtask

    task automatic test_idle_abort();
        logic [44:0] exp_v;
        @(negedge clk);
        start_v[0] = 1'b1; abort_v[0] = 1'b1; iter_v[0] = 32'd3;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start_v[0] = 1'b0; abort_v[0] = 1'b0;
            exp_v = 45'(last_cnt[0]);
            vectors++;
            if (pack_obs(0) !== exp_v) begin
                miscompares++;
                $display("FAIL idle_abort cycle %0d: got %h want %h", k, pack_obs(0), exp_v);
            end
        end
    endtask

    task automatic test_max_iter();
        run_check(1, "max_iter", 64'h0000_0000_FFFF_FFFF, 20, 21, 1);
    endtask

    task automatic test_random();
        repeat (8) begin
            int     d   = int'($urandom_range(0, 1));
            int     lat = (d == 1) ? 3 : 1;
            longint n   = longint'($urandom_range(1, 4));
            longint a   = -1;
            if ($urandom_range(0, 1) == 1) a = longint'($urandom_range(1, 3 * (lat + 1) * int'(n)));
            if (a >= 0) run_check(d, "random_abort", n, a, a + 1, 1);
            else        run_check(d, "random_run", n, -1, done_cycle(lat, n) + 1, 1);
        end
    endtask

    task automatic test_async_reset();
        logic [44:0] exp_v;
        @(negedge clk);
        start_v[0] = 1'b1; iter_v[0] = 32'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            exp_v = model(1, 2, k, -1);
            vectors++;
            if (pack_obs(0) !== exp_v) begin
                miscompares++;
                $display("FAIL async_pre cycle %0d: got %h want %h", k, pack_obs(0), exp_v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (pack_obs(0) !== 45'd0 || st_v[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset_now: got %h st %0d want 0", pack_obs(0), st_v[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if (pack_obs(0) !== 45'd0 || st_v[0] !== 3'd0) begin
                miscompares++;
                $display("FAIL async_reset_idle cycle %0d: got %h want 0", k, pack_obs(0));
            end
        end
        last_cnt[0] = '0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_two_iter();
        test_zero_iter();
        test_lat3();
        test_abort();
        test_idle_abort();
        test_max_iter();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
